// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Shares the single Common Data Bus among the functional units of the
// out-of-order core. Each FU hands over a completed destination
// physical-register tag through a valid/ready handshake into a one-entry
// holding slot. A round-robin arbiter then broadcasts one tag per cycle on a
// registered CDB output that feeds the map table, reservation stations and ROB.
//
// Build option:
//   CDB_FIXED_PRIO_EN  defined   -> fixed priority, lowest-index full slot wins
//                                   (no rotating pointer; high FUs may starve)
//                      undefined -> round-robin starting after the last winner
//
// Ports:
//   clock      in   clock, all state updates on posedge
//   reset      in   synchronous, active-high reset (overrides everything)
//   flush      in   synchronous squash of all held completions
//   fu_valid   in   [NUM_FU]          FU i presents a completed tag
//   fu_tag     in   [NUM_FU*PREG_W]   tag of FU i at [i*PREG_W +: PREG_W]
//   fu_ready   out  [NUM_FU]          holding slot i can accept this cycle
//   cdb_valid  out  broadcast valid this cycle
//   cdb_tag    out  [PREG_W+2]        {valid, phys reg, ready}; zero when idle
//   cdb_src    out  [clog2(NUM_FU)]   FU index of the current broadcast

`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif

module cdb_arbiter #(
    parameter int NUM_FU = 4,
    parameter int PREG_W = $clog2(`PHYS_REG_SZ)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [NUM_FU-1:0]          fu_valid,
    input  logic [NUM_FU*PREG_W-1:0]   fu_tag,
    output logic [NUM_FU-1:0]          fu_ready,
    output logic                       cdb_valid,
    output logic [PREG_W+1:0]          cdb_tag,
    output logic [$clog2(NUM_FU)-1:0]  cdb_src
);

    localparam int                SRC_W    = $clog2(NUM_FU);
    localparam logic [SRC_W:0]    NUM_FU_X = (SRC_W+1)'(NUM_FU);
    localparam logic [SRC_W-1:0]  LAST_IDX = SRC_W'(NUM_FU - 1);

    logic [NUM_FU-1:0]  hold_valid_q, hold_valid_d;
    logic [PREG_W-1:0]  hold_tag_q [NUM_FU];
    logic [PREG_W-1:0]  hold_tag_d [NUM_FU];
    logic               cdb_valid_q, cdb_valid_d;
    logic [PREG_W+1:0]  cdb_tag_q, cdb_tag_d;
    logic [SRC_W-1:0]   cdb_src_q, cdb_src_d;

    logic [NUM_FU-1:0]  grant;
    logic [NUM_FU-1:0]  accept;
    logic               gnt_any;
    logic [SRC_W-1:0]   gnt_idx;
    logic [SRC_W-1:0]   scan_base;

`ifdef CDB_FIXED_PRIO_EN
    assign scan_base = '0;
`else
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    assign scan_base = rr_ptr_q;
`endif

    // Scan slots starting at scan_base, wrapping modulo NUM_FU; first full
    // slot wins. The wrap is an explicit subtract so non-power-of-two
    // NUM_FU also works.
    always_comb begin
        logic [SRC_W:0] pos;
        pos     = '0;
        grant   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            pos = {1'b0, scan_base} + (SRC_W+1)'(k);
            if (pos >= NUM_FU_X) begin
                pos = pos - NUM_FU_X;
            end
            if (!gnt_any && hold_valid_q[pos[SRC_W-1:0]]) begin
                gnt_any                = 1'b1;
                gnt_idx                = pos[SRC_W-1:0];
                grant[pos[SRC_W-1:0]]  = 1'b1;
            end
        end
    end

    // Ready comes from registered state only; the grant term lets a slot
    // that drains this cycle refill on the same edge (1 tag/cycle per FU).
    assign fu_ready = ~hold_valid_q | grant;
    assign accept   = fu_valid & fu_ready;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_tag_d   = hold_tag_q;
        cdb_valid_d  = 1'b0;
        cdb_tag_d    = '0;
        cdb_src_d    = cdb_src_q;
`ifndef CDB_FIXED_PRIO_EN
        rr_ptr_d     = rr_ptr_q;
`endif
        if (flush) begin
            // Squash: drop held tags, suppress the broadcast and any accept.
            hold_valid_d = '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (accept[i]) begin
                    hold_valid_d[i] = 1'b1;
                    hold_tag_d[i]   = fu_tag[i*PREG_W +: PREG_W];
                end else if (grant[i]) begin
                    hold_valid_d[i] = 1'b0;
                end
            end
            if (gnt_any) begin
                cdb_valid_d = 1'b1;
                cdb_tag_d   = {1'b1, hold_tag_q[gnt_idx], 1'b1};
                cdb_src_d   = gnt_idx;
`ifndef CDB_FIXED_PRIO_EN
                rr_ptr_d    = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_valid_q <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                hold_tag_q[i] <= '0;
            end
            cdb_valid_q  <= 1'b0;
            cdb_tag_q    <= '0;
            cdb_src_q    <= '0;
`ifndef CDB_FIXED_PRIO_EN
            rr_ptr_q     <= '0;
`endif
        end else begin
            hold_valid_q <= hold_valid_d;
            for (int i = 0; i < NUM_FU; i++) begin
                hold_tag_q[i] <= hold_tag_d[i];
            end
            cdb_valid_q  <= cdb_valid_d;
            cdb_tag_q    <= cdb_tag_d;
            cdb_src_q    <= cdb_src_d;
`ifndef CDB_FIXED_PRIO_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios plus random traffic, checked
// by a scoreboard fed from a cycle-level reference model of the CDB rules.
module tb_cdb_arbiter;

    localparam int N = 4;
    localparam int W = 6;

    logic             clock = 1'b0;
    logic             reset;
    logic             flush;
    logic [N-1:0]     fu_valid;
    logic [N*W-1:0]   fu_tag;
    logic [N-1:0]     fu_ready;
    logic             cdb_valid;
    logic [W+1:0]     cdb_tag;
    logic [1:0]       cdb_src;

    cdb_arbiter #(.NUM_FU(N), .PREG_W(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .fu_valid  (fu_valid),
        .fu_tag    (fu_tag),
        .fu_ready  (fu_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_src   (cdb_src)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit mon_en      = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int tag;
        int src;
        int at;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: which slots hold a tag, what tag, and where the
    // next round-robin scan starts. FU side: pending request per FU.
    bit occ  [N];
    int mtag [N];
    int rr = 0;
    bit want [N];
    int wtag [N];

    function automatic void check(string name, longint act, longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: pops an expected broadcast whenever the DUT shows one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                if (cdb_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_broadcast: got tag %0d src %0d, expected none (cycle %0d)",
                                 cdb_tag, cdb_src, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("cdb_tag", cdb_tag, (longint'(1) << (W+1)) | (longint'(e.tag) << 1) | 1);
                        check("cdb_src", cdb_src, e.src);
                        check("cdb_cycle", cyc, e.at);
                    end
                end else begin
                    check("cdb_valid_known", (cdb_valid === 1'b0) ? 1 : 0, 1);
                    check("idle_cdb_tag", cdb_tag, 0);
                end
            end
        end
    end

    // Apply one cycle of stimulus (called at a negedge), advance the model,
    // and return at the following negedge.
    task automatic step(input bit rst_v, input bit fl_v);
        int           w;
        logic [N-1:0] mready;
        reset = rst_v;
        flush = fl_v;
        for (int i = 0; i < N; i++) begin
            fu_valid[i]        = want[i];
            fu_tag[i*W +: W]   = W'(wtag[i]);
        end
        w = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (rr + k) % N;
            if (w < 0 && occ[idx]) w = idx;
        end
        for (int i = 0; i < N; i++) begin
            mready[i] = !occ[i] || (w == i);
        end
        if (mon_en) check("fu_ready", fu_ready, mready);
        if (rst_v) begin
            for (int i = 0; i < N; i++) begin
                occ[i]  = 1'b0;
                want[i] = 1'b0;
            end
            rr = 0;
        end else if (fl_v) begin
            for (int i = 0; i < N; i++) occ[i] = 1'b0;
        end else begin
            if (w >= 0) begin
                exp_q.push_back('{tag: mtag[w], src: w, at: cyc + 1});
`ifdef CDB_FIXED_PRIO_EN
                rr = 0;
`else
                rr = (w + 1) % N;
`endif
            end
            for (int i = 0; i < N; i++) begin
                if (want[i] && mready[i]) begin
                    occ[i]  = 1'b1;
                    mtag[i] = wtag[i];
                    want[i] = 1'b0;
                end else if (w == i) begin
                    occ[i] = 1'b0;
                end
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < N; i++) want[i] = 1'b0;
        for (int c = 0; c < n; c++) step(1'b0, 1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        flush    = 1'b0;
        fu_valid = '0;
        fu_tag   = '0;
        for (int i = 0; i < N; i++) begin
            want[i] = 1'b0;
            wtag[i] = 0;
            occ[i]  = 1'b0;
            mtag[i] = 0;
        end
        @(negedge clock);

        // Reset held for two cycles
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("reset_cdb_valid", cdb_valid, 0);
        check("reset_cdb_tag", cdb_tag, 0);
        check("reset_fu_ready", fu_ready, 4'b1111);
        check("reset_cdb_src", cdb_src, 0);
        mon_en = 1'b1;

        // Single request from FU2, tag 17: visible two cycles after handshake
        want[2] = 1'b1;
        wtag[2] = 17;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("single_valid", cdb_valid, 1);
        check("single_tag", cdb_tag, 8'b1010_0011);
        check("single_src", cdb_src, 2);
        step(1'b0, 1'b0);
        check("single_after_valid", cdb_valid, 0);

        // Full contention, every FU reloads its tag on accept
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!want[i]) begin
                    want[i] = 1'b1;
                    wtag[i] = 10 + i;
                end
            end
            step(1'b0, 1'b0);
        end
        idle(6);

        // Bypass streaming from FU1 with the others idle
        for (int t = 0; t < 3; t++) begin
            want[1] = 1'b1;
            wtag[1] = 20 + t;
            check("bypass_ready1", fu_ready[1], 1);
            step(1'b0, 1'b0);
        end
        step(1'b0, 1'b0);
        check("bypass_tag_last", cdb_tag, {1'b1, 6'd22, 1'b1});
        idle(3);

        // Flush on the edge where the first grant would register
        want[0] = 1'b1; wtag[0] = 5;
        want[3] = 1'b1; wtag[3] = 9;
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("flush_valid", cdb_valid, 0);
        check("flush_ready", fu_ready, 4'b1111);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0);
            check("flush_quiet", cdb_valid, 0);
        end

        // Random traffic with occasional flush and reset
        for (int c = 0; c < 600; c++) begin
            bit fl;
            bit rs;
            for (int i = 0; i < N; i++) begin
                if (!want[i] && $urandom_range(0, 99) < 45) begin
                    want[i] = 1'b1;
                    wtag[i] = $urandom_range(0, 63);
                end
            end
            fl = ($urandom_range(0, 99) < 3);
            rs = ($urandom_range(0, 299) == 0);
            step(rs, fl);
        end
        idle(6);

        // Reset mid-operation with three slots full and a broadcast in flight
        for (int i = 0; i < 3; i++) begin
            want[i] = 1'b1;
            wtag[i] = 30 + i;
        end
        step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            want[i] = 1'b1;
            wtag[i] = 33 + i;
        end
        step(1'b0, 1'b0);
        check("prerst_valid", cdb_valid, 1);
        step(1'b1, 1'b0);
        check("midrst_cdb_valid", cdb_valid, 0);
        check("midrst_cdb_tag", cdb_tag, 0);
        check("midrst_cdb_src", cdb_src, 0);
        check("midrst_fu_ready", fu_ready, 4'b1111);
        want[3] = 1'b1;
        wtag[3] = 40;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("postrst_valid", cdb_valid, 1);
        check("postrst_src", cdb_src, 3);
        idle(4);

        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single Common Data Bus among the functional units (FUs) of the R10K-style out-of-order core. Each FU hands over a completed destination physical-register tag through a valid/ready handshake. The tag lands in a one-entry per-FU holding slot. A round-robin arbiter then broadcasts one tag per cycle on a registered CDB output, which drives the map table, the reservation stations and the ROB.

## Interface
Parameters:
- NUM_FU, 4, number of requesting functional units (≥2)
- PREG_W, $clog2(`PHYS_REG_SZ), width of a physical-register tag

Ports:
- clock  input  1  clock; all state updates on posedge
- reset  input  1  reset, synchronous, active-high
- flush  input  1  synchronous squash of all in-flight completions
- fu_valid  input  NUM_FU  FU i presents a completed tag
- fu_tag  input  NUM_FU×PREG_W  destination physical register of FU i
- fu_ready  output  NUM_FU  holding slot i can accept this cycle
- cdb_valid  output  1  CDB broadcast valid this cycle (= map-table CDB_enable)
- cdb_tag  output  TAG  broadcast tag: .valid=1, .tag=phys reg, .ready=1 when cdb_valid; all-zero otherwise
- cdb_src  output  $clog2(NUM_FU)  index of the FU whose tag is on the CDB

## Operation
- State: hold_valid[NUM_FU], hold_tag[NUM_FU], rr_ptr ($clog2(NUM_FU) bits), registered cdb_valid/cdb_tag/cdb_src.
- Grant (combinational): scan slots from rr_ptr upward, modulo NUM_FU; the first slot with hold_valid=1 gets grant[i]=1. At most one grant per cycle; no grant if all slots are empty.
- fu_ready[i] = !hold_valid[i] | grant[i]. It depends on registered state only, never on fu_valid, so there is no combinational loop.
- Accept: fu_valid[i] & fu_ready[i] at a posedge loads hold_tag[i] and sets hold_valid[i].
- Drain: grant[i] at a posedge clears hold_valid[i], unless the same edge accepts a new tag for slot i. That edge also registers cdb_valid=1, cdb_tag={1,hold_tag[i],1} and cdb_src=i, and sets rr_ptr ← (i+1) mod NUM_FU.
- No grant: cdb_valid ← 0, cdb_tag ← 0; cdb_src and rr_ptr hold their values.
- Simultaneous accept and drain on the same slot: the slot stays full with the new tag, and the old tag goes to the CDB.
- Flush: at the edge, hold_valid ← all 0, cdb_valid ← 0, cdb_tag ← 0, and nothing is accepted that cycle. fu_ready still reflects pre-edge state, but flush overrides the accept. rr_ptr is kept.
- Reset overrides flush and everything else.

## Timing
- Reset values: fu_ready = all 1, cdb_valid = 0, cdb_tag = 0, cdb_src = 0, rr_ptr = 0, hold_valid = 0.
- Latency: a handshake at edge E0 makes the tag eligible in the next cycle. The earliest broadcast is registered at E1 and visible in the cycle after E1, i.e. 2 cycles after the handshake cycle.
- Throughput: 1 broadcast per cycle total. A single FU granted every cycle sustains 1 tag per cycle through the bypass term of fu_ready.
- Fairness: with all NUM_FU slots continuously full, each FU is granted exactly once every NUM_FU cycles.
- Backpressure: fu_ready[i]=0 while slot i is full and not granted. The FU must hold fu_valid and fu_tag until it sees ready.
- Wrap-around: a grant at index NUM_FU-1 sets rr_ptr to 0.

## Configuration
- CDB_FIXED_PRIO_EN
  - Defined: fixed priority, lowest-index full slot wins; rr_ptr is not implemented and stays 0; lower FUs may starve higher ones.
  - Undefined (default): round-robin as specified above.

## Test plan
- Reset: hold reset 2 cycles → cdb_valid=0, cdb_tag=0, fu_ready=4'b1111, cdb_src=0.
- Single request: fu_valid=4'b0100, fu_tag[2]=6'd17 for one cycle → two cycles later cdb_valid=1, cdb_tag={1,17,1}, cdb_src=2; the next cycle cdb_valid=0.
- Full contention: all 4 FUs hold valid with tags 10, 11, 12, 13, reloading on each accept → CDB sequence 10, 11, 12, 13, 10, … with cdb_src 0, 1, 2, 3, 0, …
  - With CDB_FIXED_PRIO_EN defined: only tag 10 ever appears.
- Backpressure and bypass: FU1 streams tags 20, 21, 22 back-to-back while FU0 is idle → fu_ready[1] stays 1 throughout and the CDB carries 20, 21, 22 on consecutive cycles.
- Flush: load slots 0 and 3 (tags 5, 9), then assert flush in the cycle the first grant would register → cdb_valid=0 that cycle and after, fu_ready=4'b1111, and neither tag is ever broadcast.
- Reset mid-operation: assert reset with 3 slots full and cdb_valid=1 → the next cycle all outputs equal their reset values and rr_ptr=0; the first post-reset request from FU3 is granted with cdb_src=3.
